pacman_motion: RTL
==================

# pacman_motion

Per-frame Pac-Man movement controller, directly upstream of `pacman_sprite`. Each frame tick it consults the maze wall ROM through a registered-read query port, resolves turns and wall stops on the 8×8 tile grid, and advances the sprite position by one pixel. It drives `x_pac`, `y_pac`, `h_flip` and `v_flip` straight into `pacman_sprite`.

## Interface
- `PLAY_W`, 224: playfield width in pixels, a multiple of 8.
- `PLAY_H`, 248: playfield height in pixels, a multiple of 8.
- `START_X`, 104: reset x position in pixels, a multiple of 8.
- `START_Y`, 184: reset y position in pixels, a multiple of 8.
- `clk`  in  1  system/pixel clock; the block's only clock.
- `rst`  in  1  synchronous, active-low reset.
- `frame_tick`  in  1  one-cycle pulse per frame, issued in vblank.
- `freeze`  in  1  while high, ticks are ignored and all state is held.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`  in  1 each  debounced level inputs.
- `tile_x`  out  5  wall-query column, registered.
- `tile_y`  out  5  wall-query row, registered.
- `wall_q`  in  1  wall flag, valid the cycle after `tile_x`/`tile_y` are presented.
- `x_pac`, `y_pac`  out  9 each  sprite top-left position in pixels.
- `h_flip`, `v_flip`  out  1 each  sprite orientation.
- `dir`  out  2  current direction: 0=RIGHT, 1=LEFT, 2=UP, 3=DOWN.
- `moving`  out  1  high if the last tick advanced the position.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- **Request latch:** `req_dir` updates every cycle from the buttons with priority up > down > left > right. With no button pressed it holds its last value.
- **Aligned:** true when `x_pac[2:0]==0 && y_pac[2:0]==0`.
- **Neighbour tile** for direction d: `(x_pac>>3, y_pac>>3)` stepped by ±1 in d.
- **FSM states:** IDLE, Q_TURN, E_TURN, Q_FWD, E_FWD.
  - IDLE: if `frame_tick && !freeze`, load the `req_dir` neighbour into `tile_x`/`tile_y` and go to Q_TURN.
  - Q_TURN: go to E_TURN unconditionally (ROM read in flight).
  - E_TURN: resolve the turn request.
    - If `req_dir` is the reverse of `dir`, set `dir<=req_dir` regardless of `wall_q` or alignment.
    - Otherwise, if `req_dir!=dir && aligned && !wall_q`, set `dir<=req_dir`.
    - In all cases, load the neighbour of the resulting `dir` and go to Q_FWD.
  - Q_FWD: go to E_FWD unconditionally.
  - E_FWD: resolve the forward move.
    - If aligned and `wall_q`, hold position and clear `moving`.
    - Otherwise, step 1 pixel in `dir` and set `moving`.
    - Update the flips and go to IDLE.
- **Flip mapping** (`h_flip`, `v_flip`): RIGHT=(1,1), LEFT=(0,1), UP=(1,0), DOWN=(0,0).
- **Query addressing:**
  - Out-of-range neighbour columns (-1 or `PLAY_W/8`) wrap modulo `PLAY_W/8`.
  - Out-of-range rows never occur; the maze border is walled.
- **Arithmetic:** position arithmetic is 9-bit unsigned. `x_pac` is always ≤ `PLAY_W-8` and `y_pac` is always ≤ `PLAY_H-8`.
- **Tunnel wrap** (see Configuration):
  - Moving LEFT at `x_pac==0`: next x is `PLAY_W-8`.
  - Moving RIGHT at `x_pac==PLAY_W-8`: next x is 0.
- **Reset values:**
  - `x_pac=START_X`, `y_pac=START_Y`.
  - `dir=LEFT`, `req_dir=LEFT`, `h_flip=0`, `v_flip=1`.
  - `moving=0`, `busy=0`, `tile_x=0`, `tile_y=0`, FSM=IDLE.

## Timing
- `frame_tick` is sampled only in IDLE. A tick arriving while `busy` is dropped, not queued.
- Tick sampled at edge T0: turn query presented T0–T1, `wall_q` sampled at T2, forward query presented T2–T3, `wall_q` sampled at T4.
- `x_pac`, `y_pac`, the flips, `dir` and `moving` all change together at T4: latency 4 edges.
- `busy` is high from T0 to T4 (4 cycles).
- `x_pac`/`y_pac` are stable for the rest of the frame, so the sprite renderer never sees a mid-scanline change when ticks come in vblank.
- `freeze` high in IDLE blocks the tick. `freeze` asserted mid-sequence does not abort it; the sequence completes.
- `rst` low in any state: all registers take their reset values at that edge, and no position update occurs.

## Configuration
- `PACMAN_TUNNEL_WRAP_EN` defined:
  - Column queries wrap modulo `PLAY_W/8`.
  - Position wraps at the left/right edges as described in Operation.
- Not defined:
  - Any neighbour outside the playfield is treated as a wall without regard to `wall_q` (`moving=0` at the edge).
  - The ROM query still issues, with `tile_x` clamped to the edge column.

## Test plan
1. **Reset and idle.** Hold `rst` low for 3 cycles, then release with no tick. Expect `x_pac=104`, `y_pac=184`, `h_flip=0`, `v_flip=1`, `dir=1`, `moving=0`, `busy=0`.
2. **Straight run.** Free corridor, `btn_left` held, 8 ticks. Expect `x_pac` stepping 104→96, one pixel per tick, each update exactly 4 edges after its tick, with `moving=1`.
3. **Wall stop.** Aligned at (96,184), wall at tile (11,23), LEFT held, tick. Expect the position held and `moving=0`.
4. **Turn at alignment.** Pressing UP at (100,184) with tile (12,22) free gives no turn (`dir` stays LEFT, x becomes 99). At (96,184) with tile (12,22) free, UP gives `dir=2`, flips (1,0), `y_pac=183`.
5. **Mid-tile reversal.** At (100,184) moving LEFT, press RIGHT. Expect `dir=0`, flips (1,1), `x_pac=101`, with `wall_q` irrelevant.
6. **Tunnel and dropped tick.**
   - At (0,112) moving LEFT: with the macro, `x_pac` becomes 216; without it, `x_pac` stays 0 and `moving=0`.
   - A second tick 2 cycles after the first is dropped: exactly one pixel of movement.

Source files
------------

// File: rtl/pacman_motion.sv
// pacman_motion: per-frame Pac-Man movement controller driving pacman_sprite.
// Ports: clk, rst (sync active-low); frame_tick, freeze; btn_up/down/left/right
//   request buttons; tile_x/tile_y wall-ROM query (registered), wall_q ROM
//   answer one cycle later; x_pac/y_pac/h_flip/v_flip to the sprite;
//   dir/moving/busy status.
// An accepted tick updates position, flips, dir and moving together 4 edges
// later. busy is high for those 4 cycles, and ticks arriving then are dropped.
// Optional feature macro PACMAN_TUNNEL_WRAP_EN: left/right tunnel wrap of
// position and column queries. When undefined, the playfield edge acts as a wall.
module pacman_motion #(
  parameter int PLAY_W  = 224,
  parameter int PLAY_H  = 248,
  parameter int START_X = 104,
  parameter int START_Y = 184
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       freeze,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic [4:0] tile_x,
  output logic [4:0] tile_y,
  input  logic       wall_q,
  output logic [8:0] x_pac,
  output logic [8:0] y_pac,
  output logic       h_flip,
  output logic       v_flip,
  output logic [1:0] dir,
  output logic       moving,
  output logic       busy
);

  localparam int         COLS     = PLAY_W / 8;
  localparam logic [4:0] LAST_COL = 5'(COLS - 1);
  localparam logic [8:0] X_MAX    = 9'(PLAY_W - 8);
  localparam int         ROWS     = PLAY_H / 8;

`ifdef PACMAN_TUNNEL_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  localparam logic [1:0] DIR_R = 2'd0;
  localparam logic [1:0] DIR_L = 2'd1;
  localparam logic [1:0] DIR_U = 2'd2;

  typedef enum logic [2:0] {IDLE, Q_TURN, E_TURN, Q_FWD, E_FWD} state_t;

  state_t     state_q, state_d;
  logic [1:0] req_q, req_d;     // latched button request
  logic [1:0] turn_q, turn_d;   // request captured with the tick, matches the turn query
  logic [1:0] nxt_q, nxt_d;     // resolved direction, committed to dir_q at the end
  logic [1:0] dir_q, dir_d;
  logic [8:0] x_q, x_d, y_q, y_d;
  logic [4:0] tx_q, tx_d, ty_q, ty_d;
  logic       hf_q, hf_d, vf_q, vf_d, mov_q, mov_d;

  logic       aligned;
  logic [4:0] col, row;
  logic [1:0] res_dir;
  logic [9:0] req_tile, res_tile;

  // Neighbour tile {col,row} one step in direction d; columns wrap or clamp.
  function automatic logic [9:0] nbr_tile(input logic [1:0] d, input logic [4:0] c,
                                          input logic [4:0] r);
    logic [4:0] nc, nr;
    nc = c;
    nr = r;
    case (d)
      DIR_R:   nc = (c == LAST_COL) ? (WRAP_EN ? 5'd0 : LAST_COL) : c + 5'd1;
      DIR_L:   nc = (c == 5'd0) ? (WRAP_EN ? LAST_COL : 5'd0) : c - 5'd1;
      DIR_U:   nr = r - 5'd1;
      default: nr = r + 5'd1;
    endcase
    return {nc, nr};
  endfunction

  // True when the neighbour lies outside the playfield and the edge acts as a wall.
  function automatic logic edge_wall(input logic [1:0] d, input logic [4:0] c);
    return !WRAP_EN && (((d == DIR_R) && (c == LAST_COL)) || ((d == DIR_L) && (c == 5'd0)));
  endfunction

  assign aligned = (x_q[2:0] == 3'd0) && (y_q[2:0] == 3'd0);
  assign col     = x_q[7:3];
  assign row     = y_q[7:3];

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    turn_d  = turn_q;
    nxt_d   = nxt_q;
    dir_d   = dir_q;
    x_d     = x_q;
    y_d     = y_q;
    tx_d    = tx_q;
    ty_d    = ty_q;
    hf_d    = hf_q;
    vf_d    = vf_q;
    mov_d   = mov_q;

    // Reversal is always allowed; other turns need an aligned, open neighbour.
    res_dir = dir_q;
    if (turn_q == (dir_q ^ 2'b01)) begin
      res_dir = turn_q;
    end else if ((turn_q != dir_q) && aligned && !wall_q && !edge_wall(turn_q, col)) begin
      res_dir = turn_q;
    end
    req_tile = nbr_tile(req_q, col, row);
    res_tile = nbr_tile(res_dir, col, row);

    if (!freeze) begin
      if (btn_up)         req_d = 2'd2;
      else if (btn_down)  req_d = 2'd3;
      else if (btn_left)  req_d = 2'd1;
      else if (btn_right) req_d = 2'd0;
    end

    case (state_q)
      IDLE: begin
        if (frame_tick && !freeze) begin
          {tx_d, ty_d} = req_tile;
          turn_d       = req_q;
          state_d      = Q_TURN;
        end
      end
      Q_TURN: state_d = E_TURN;
      E_TURN: begin
        nxt_d        = res_dir;
        {tx_d, ty_d} = res_tile;
        state_d      = Q_FWD;
      end
      Q_FWD: state_d = E_FWD;
      E_FWD: begin
        dir_d = nxt_q;
        hf_d  = ~nxt_q[0];
        vf_d  = ~nxt_q[1];
        if (aligned && (wall_q || edge_wall(nxt_q, col))) begin
          mov_d = 1'b0;
        end else begin
          mov_d = 1'b1;
          case (nxt_q)
            DIR_R:   x_d = (WRAP_EN && (x_q == X_MAX)) ? 9'd0 : x_q + 9'd1;
            DIR_L:   x_d = (WRAP_EN && (x_q == 9'd0)) ? X_MAX : x_q - 9'd1;
            DIR_U:   y_d = y_q - 9'd1;
            default: y_d = y_q + 9'd1;
          endcase
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q   <= DIR_L;
      turn_q  <= DIR_L;
      nxt_q   <= DIR_L;
      dir_q   <= DIR_L;
      x_q     <= 9'(START_X);
      y_q     <= 9'(START_Y);
      tx_q    <= 5'd0;
      ty_q    <= 5'd0;
      hf_q    <= 1'b0;
      vf_q    <= 1'b1;
      mov_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      turn_q  <= turn_d;
      nxt_q   <= nxt_d;
      dir_q   <= dir_d;
      x_q     <= x_d;
      y_q     <= y_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      hf_q    <= hf_d;
      vf_q    <= vf_d;
      mov_q   <= mov_d;
    end
  end

  assign tile_x = tx_q;
  assign tile_y = ty_q;
  assign x_pac  = x_q;
  assign y_pac  = y_q;
  assign h_flip = hf_q;
  assign v_flip = vf_q;
  assign dir    = dir_q;
  assign moving = mov_q;
  assign busy   = (state_q != IDLE) && (ROWS > 0);

endmodule
